wm_panel_ctrl: RTL and testbench
================================

# wm_panel_ctrl

Front-panel controller driving the `washing_machine` FSM's `start`/`pause`/`done` interface, replacing the stimulus a bench would otherwise apply. It:
- debounces two raw push-buttons,
- issues a one-cycle `start` pulse and a level `pause`,
- watches `done` for completion,
- counts completed washes,
- flags a fault if a run exceeds a watchdog limit.

It sits between the panel buttons and the washing machine, in the same clock domain.

## Interface
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a button change is accepted (≥2)
- TIMEOUT_CYCLES, 1000, maximum unpaused RUN cycles before FAULT (≥2)
- clk  input  1  system clock, rising-edge
- res  input  1  reset; asynchronous, active-high
- btn_start  input  1  raw start/acknowledge button, asynchronous to clk
- btn_pause  input  1  raw pause/resume toggle button, asynchronous to clk
- done  input  1  completion flag from washing machine, synchronous to clk
- start  output  1  one-cycle start pulse to washing machine
- pause  output  1  pause level to washing machine
- busy  output  1  high in START, RUN, PAUSED
- fault  output  1  sticky watchdog fault
- wash_count  output  8  completed washes, saturating at 255
- led_state  output  2  0 idle, 1 running, 2 paused, 3 fault

## Operation
- **Button path (per button):**
  - 2-flop synchronizer feeds a debounced level `db`.
  - A counter increments while the synchronizer output ≠ `db` and clears when they are equal.
  - `db` takes the synchronized value when the counter reaches DEBOUNCE_CYCLES−1.
  - Press event = `db` rising edge, one cycle wide. Releases generate no event.
- **Completion detect:** `done` rising edge, using a registered `done_prev` (reset 0).
- **FSM states:** IDLE, START, RUN, PAUSED, FINISH, FAULT. Reset → IDLE.
- **IDLE:** start press → START. Pause presses ignored.
- **START:** one cycle, `start`=1. Watchdog cleared. → RUN unconditionally.
- **RUN:**
  - done edge → FINISH.
  - else watchdog = TIMEOUT_CYCLES−1 → FAULT.
  - else pause press → PAUSED.
  - Watchdog increments each cycle.
- **PAUSED:**
  - done edge → FINISH.
  - else pause press → RUN.
  - Watchdog holds. `pause`=1.
- **FINISH:** one cycle. `wash_count` += 1, saturating at 255. → IDLE.
- **FAULT:**
  - `fault`=1, `pause`=0.
  - Start press → IDLE and clears `fault`. All other inputs ignored.
- **Start presses in RUN/PAUSED/FINISH:** ignored (no second `start` pulse).
- **Priority, same cycle:** done edge > watchdog expiry > pause press.
- **Outputs:** all registered, decoded from next-state.
- **Watchdog width:** $clog2(TIMEOUT_CYCLES+1) bits. It never wraps: FAULT is taken before overflow.
- **`wash_count`:** never cleared except by `res`.

## Timing
- **Reset values:** `start`=0, `pause`=0, `busy`=0, `fault`=0, `wash_count`=0, `led_state`=0. Also: FSM IDLE, debouncers `db`=0, synchronizers 0, watchdog 0.
- **Button latency:** for a button held stable high from clock edge k, the press event is high in cycle k+1+DEBOUNCE_CYCLES.
- **Start latency:** `start` is high for exactly the one cycle after the press event, i.e. starting at edge k+2+DEBOUNCE_CYCLES. With the default of 4, that is edge k+6.
- **Pause latency:**
  - `pause` rises on the edge after the press event.
  - `pause` falls on the edge after the next press event.
- **Glitches:** a button glitch shorter than DEBOUNCE_CYCLES cycles produces no event.
- **Completion latency:**
  - done rising at edge d → FINISH at edge d+1 (`wash_count` updates at d+1).
  - IDLE at d+2; `busy` falls at d+2.
- **Fault timing:** FAULT is entered exactly TIMEOUT_CYCLES unpaused RUN cycles after START. `pause` drops in the same cycle.
- **done held high:** only its rising edge counts. A `done` already high when START is entered does not complete the new wash.
- **Reset mid-operation:** `res` asserted asynchronously forces all outputs to reset values immediately. After release, the first press requires the full debounce latency.

## Test plan
- Reset, then hold btn_start 10 cycles (DEBOUNCE_CYCLES=4) → exactly one `start` pulse, 6 edges after first high sample. `busy`=1, `led_state`=1.
- btn_start with a 2-cycle glitch → no `start`. State stays IDLE.
- In RUN, press pause, hold 20 cycles, press again → `pause` high between the two events. Watchdog frozen: FAULT arrives 20+ cycles later than an unpaused run would.
- done pulse in RUN → FINISH then IDLE. `wash_count` 0→1. Repeat 256 washes → `wash_count` stays 255.
- TIMEOUT_CYCLES=16, no done → FAULT after 16 RUN cycles: `fault`=1, `led_state`=3, `pause`=0. Start press clears to IDLE without issuing `start`.
- done edge coincident with pause press and watchdog expiry → FINISH, `pause`=0, `fault`=0. Assert `res` in PAUSED → all outputs reset immediately.

Source files
------------

// File: rtl/wm_panel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : wm_panel_ctrl
//  Purpose  : Front-panel controller for the washing machine FSM. Debounces
//             the start and pause buttons, issues a one-cycle start pulse and
//             a level pause, detects completion from the done flag, counts
//             completed washes (saturating) and raises a sticky fault when an
//             unpaused run exceeds the watchdog limit.
//  Ports    : clk        - system clock, rising edge
//             res        - asynchronous active-high reset
//             btn_start  - raw start/acknowledge button (asynchronous)
//             btn_pause  - raw pause/resume toggle button (asynchronous)
//             done       - completion flag from washing machine
//             start      - one-cycle start pulse
//             pause      - pause level
//             busy       - high while a wash is in progress
//             fault      - sticky watchdog fault
//             wash_count - completed washes, saturating at 255
//             led_state  - 0 idle, 1 running, 2 paused, 3 fault
//  Revision : 1.0 - initial release
// ============================================================================
module wm_panel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       res,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       done,
  output logic       start,
  output logic       pause,
  output logic       busy,
  output logic       fault,
  output logic [7:0] wash_count,
  output logic [1:0] led_state
);

  localparam int c_db_w = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int c_wd_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_RUN    = 3'd2,
    S_PAUSED = 3'd3,
    S_FINISH = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // Button path: bit 0 = start button, bit 1 = pause button
  // --------------------------------------------------------------------------
  logic [1:0] w_btn_raw;
  logic [1:0] w_press;

  assign w_btn_raw = {btn_pause, btn_start};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic              sync1_q;
    logic              sync2_q;
    logic              db_q;
    logic              db_prev_q;
    logic [c_db_w-1:0] cnt_q;

    always_ff @(posedge clk or posedge res) begin
      if (res) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        db_q      <= 1'b0;
        db_prev_q <= 1'b0;
        cnt_q     <= '0;
      end else begin
        sync1_q   <= w_btn_raw[gi];
        sync2_q   <= sync1_q;
        db_prev_q <= db_q;
        // The counter only runs while the synchronized level disagrees with
        // the accepted level; any bounce back resets it.
        if (sync2_q == db_q) begin
          cnt_q <= '0;
        end else if (cnt_q == c_db_last) begin
          db_q  <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + c_db_w'(1);
        end
      end
    end

    // Only the accepted rising edge is an event; releases are silent.
    assign w_press[gi] = db_q & ~db_prev_q;
  end

  logic w_start_press;
  logic w_pause_press;

  assign w_start_press = w_press[0];
  assign w_pause_press = w_press[1];

  // --------------------------------------------------------------------------
  // Completion edge detect
  // --------------------------------------------------------------------------
  logic done_prev_q;
  logic w_done_edge;

  assign w_done_edge = done & ~done_prev_q;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  state_t            state_q;
  state_t            state_d;
  logic [c_wd_w-1:0] wd_q;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= S_IDLE;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_prev_q <= done;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_start_press) state_d = S_START;
      end
      S_START: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        // Completion wins over watchdog expiry, which wins over pause.
        if (w_done_edge)            state_d = S_FINISH;
        else if (wd_q == c_wd_last) state_d = S_FAULT;
        else if (w_pause_press)     state_d = S_PAUSED;
      end
      S_PAUSED: begin
        if (w_done_edge)        state_d = S_FINISH;
        else if (w_pause_press) state_d = S_RUN;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      S_FAULT: begin
        if (w_start_press) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Watchdog counts RUN cycles only, so time spent paused does not age the
  // run. FAULT is taken at TIMEOUT_CYCLES-1, so the counter peaks at
  // TIMEOUT_CYCLES and never wraps.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wd_q <= '0;
    end else if (state_q == S_START) begin
      wd_q <= '0;
    end else if (state_q == S_RUN) begin
      wd_q <= wd_q + c_wd_w'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs, decoded from the next state
  // --------------------------------------------------------------------------
  logic       start_q;
  logic       pause_q;
  logic       busy_q;
  logic       fault_q;
  logic [7:0] wash_count_q;
  logic [1:0] led_state_q;
  logic [1:0] w_led_d;

  always_comb begin
    w_led_d = 2'd0;
    case (state_d)
      S_START, S_RUN: w_led_d = 2'd1;
      S_PAUSED:       w_led_d = 2'd2;
      S_FAULT:        w_led_d = 2'd3;
      default:        w_led_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      start_q      <= 1'b0;
      pause_q      <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      wash_count_q <= 8'd0;
      led_state_q  <= 2'd0;
    end else begin
      start_q <= (state_d == S_START);
      pause_q <= (state_d == S_PAUSED);
      // busy also covers the single FINISH cycle so it drops together with
      // the return to IDLE.
      busy_q  <= (state_d == S_START) || (state_d == S_RUN) ||
                 (state_d == S_PAUSED) || (state_d == S_FINISH);
      fault_q <= (state_d == S_FAULT);
      led_state_q <= w_led_d;
      // FINISH lasts exactly one cycle, so this increments once per wash.
      if ((state_d == S_FINISH) && (wash_count_q != 8'hFF)) begin
        wash_count_q <= wash_count_q + 8'd1;
      end
    end
  end

  assign start      = start_q;
  assign pause      = pause_q;
  assign busy       = busy_q;
  assign fault      = fault_q;
  assign wash_count = wash_count_q;
  assign led_state  = led_state_q;

endmodule
`default_nettype wire

// File: tb/tb_wm_panel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wm_panel_ctrl
//  Purpose  : Self-checking bench for wm_panel_ctrl (DEBOUNCE_CYCLES=4,
//             TIMEOUT_CYCLES=16). Expected start pulses and wash_count
//             updates are queued when stimulus is applied and popped by a
//             monitor when the DUT produces them; directed checks cover
//             state levels at known cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wm_panel_ctrl;

  logic       clk;
  logic       res;
  logic       btn_start;
  logic       btn_pause;
  logic       done;
  logic       start;
  logic       pause;
  logic       busy;
  logic       fault;
  logic [7:0] wash_count;
  logic [1:0] led_state;

  wm_panel_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .res       (res),
    .btn_start (btn_start),
    .btn_pause (btn_pause),
    .done      (done),
    .start     (start),
    .pause     (pause),
    .busy      (busy),
    .fault     (fault),
    .wash_count(wash_count),
    .led_state (led_state)
  );

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t  start_exp[$];
  ev_t  wc_exp[$];
  ev_t  mon_ev;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   wc_model = 0;
  logic [7:0] wc_prev = 8'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after the n-th rising edge, cyc == n.
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press start from IDLE: the pulse is due 7 edges after the edge we are
  // sitting on (first high sample k = cyc+1, pulse at k+6).
  task automatic do_start();
    btn_start = 1'b1;
    start_exp.push_back('{cyc + 7, 0});
    step(7);
    chk("start_level", start, 1);
    chk("start_busy", busy, 1);
    chk("start_led", led_state, 1);
    btn_start = 1'b0;
  endtask

  task automatic raise_done();
    done = 1'b1;
    if (wc_model < 255) begin
      wc_model++;
      wc_exp.push_back('{cyc + 1, wc_model});
    end
  endtask

  task automatic do_done();
    raise_done();
    step(1);
    done = 1'b0;
    step(1);
  endtask

  task automatic clear_fault();
    btn_start = 1'b1;
    step(7);
    chk("clear_fault", fault, 0);
    chk("clear_led", led_state, 0);
    chk("clear_busy", busy, 0);
    btn_start = 1'b0;
    step(8);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_pause"}, pause, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_wash_count"}, wash_count, 0);
    chk({tag, "_led"}, led_state, 0);
  endtask

  // Scoreboard monitor: every start pulse and every wash_count change must
  // match the head of its expectation queue.
  always @(negedge clk) begin
    if (res) begin
      wc_prev = 8'd0;
    end else begin
      if (start === 1'b1) begin
        chk("start_expected", start_exp.size() != 0, 1);
        if (start_exp.size() != 0) begin
          mon_ev = start_exp.pop_front();
          chk("start_cycle", cyc, mon_ev.cyc);
        end
      end
      if (wash_count !== wc_prev) begin
        chk("wc_expected", wc_exp.size() != 0, 1);
        if (wc_exp.size() != 0) begin
          mon_ev = wc_exp.pop_front();
          chk("wc_cycle", cyc, mon_ev.cyc);
          chk("wc_value", wash_count, mon_ev.val);
        end
      end
      wc_prev = wash_count;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    int q;
    res       = 1'b1;
    btn_start = 1'b0;
    btn_pause = 1'b0;
    done      = 1'b0;

    // Reset state
    step(3);
    chk_reset_outputs("reset");
    res = 1'b0;
    step(2);

    // Short glitch on start: no event, stay IDLE
    btn_start = 1'b1;
    step(2);
    btn_start = 1'b0;
    step(10);
    chk("glitch_led", led_state, 0);
    chk("glitch_busy", busy, 0);

    // Pause press while IDLE is ignored
    btn_pause = 1'b1;
    step(7);
    chk("idle_pause", pause, 0);
    chk("idle_pause_led", led_state, 0);
    btn_pause = 1'b0;
    step(8);

    // First wash: start, done -> FINISH -> IDLE, count 0 -> 1
    do_start();
    step(2);
    do_done();
    chk("wash1_count", wash_count, 1);
    chk("wash1_busy", busy, 0);
    chk("wash1_led", led_state, 0);
    step(6);

    // Plain watchdog: FAULT after 16 RUN cycles
    do_start();
    step(16);
    chk("wd_before", fault, 0);
    step(1);
    chk("wd_fault", fault, 1);
    chk("wd_led", led_state, 3);
    chk("wd_pause", pause, 0);
    chk("wd_busy", busy, 0);
    clear_fault();

    // Pause freezes the watchdog
    do_start();
    step(2);
    btn_pause = 1'b1;
    step(7);
    chk("pause_rise", pause, 1);
    chk("pause_led", led_state, 2);
    btn_pause = 1'b0;
    step(20);
    q = cyc;
    btn_pause = 1'b1;
    step(6);
    chk("pause_held", pause, 1);
    step(1);
    chk("pause_fall", pause, 0);
    chk("resume_led", led_state, 1);
    btn_pause = 1'b0;
    step(7);
    chk("frozen_wd_before", fault, 0);
    chk("frozen_wd_cycle", cyc, q + 14);
    step(1);
    chk("frozen_wd_fault", fault, 1);
    chk("frozen_wd_led", led_state, 3);
    clear_fault();

    // Done edge, pause press and watchdog expiry in the same cycle
    do_start();
    step(10);
    btn_pause = 1'b1;
    step(6);
    raise_done();
    step(1);
    chk("coinc_pause", pause, 0);
    chk("coinc_fault", fault, 0);
    done      = 1'b0;
    btn_pause = 1'b0;
    step(1);
    chk("coinc_idle_busy", busy, 0);
    chk("coinc_idle_fault", fault, 0);
    chk("coinc_idle_led", led_state, 0);
    step(8);

    // Many washes: count saturates at 255
    for (int i = 0; i < 256; i++) begin
      do_start();
      step(2);
      do_done();
      step(6);
    end
    chk("saturated", wash_count, 255);

    // Asynchronous reset while PAUSED
    do_start();
    step(2);
    btn_pause = 1'b1;
    step(7);
    chk("pre_reset_pause", pause, 1);
    btn_pause = 1'b0;
    #2;
    res = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    step(2);
    res = 1'b0;
    wc_model = 0;
    step(1);

    // First press after reset needs the full debounce latency
    do_start();
    step(10);

    chk("start_queue_empty", start_exp.size(), 0);
    chk("wc_queue_empty", wc_exp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
